// File: rtl/sma_pulse_gen.sv
// sma_pulse_gen: Avalon-MM programmable pulse-train generator for the SMA output.
// A rising edge on trigger_in launches a burst of BURST pulses, each HIGH_CNT
// cycles high and LOW_CNT cycles low. BURST = 0 selects continuous mode, which
// runs for as long as trigger_in stays high at each LOW-phase end.
//
// Register map (32-bit words):
//   0 HIGH_CNT  pulse high time in cycles (0 behaves as 1), reset 1
//   1 LOW_CNT   pulse low time in cycles  (0 behaves as 1), reset 1
//   2 BURST     pulses per trigger, 0 = continuous,         reset 1
//   3 CTRL      write bit0 = abort; read bit0 = busy, bits 31:16 = PULSES
module sma_pulse_gen #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        trigger_in,
  output logic        sma_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ADDR_HIGH = 2'd0;
  localparam logic [1:0] ADDR_LOW  = 2'd1;
  localparam logic [1:0] ADDR_BRST = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Programmable fields
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] burst;

  // Sequencer state
  state_t           state, state_nxt;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
  logic [CNT_W-1:0] pulses, pulses_nxt;
  logic             trig_d;

  // Derived strobes
  logic             wr_en;
  logic             abort;
  logic             trig_edge;
  logic [CNT_W-1:0] high_load;
  logic [CNT_W-1:0] low_load;
  logic             burst_more;

  // Only the low CNT_W bits carry field data and bit0 carries abort; folding
  // the whole bus here keeps every bit visibly consumed.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign abort     = wr_en && (address == ADDR_CTRL) && writedata[0];
  assign trig_edge = trigger_in & ~trig_d;

  // Phase loads use max(field,1)-1 so that a programmed 0 behaves as 1 cycle.
  assign high_load = (high_cnt == CNT_ZERO) ? CNT_ZERO : high_cnt - CNT_ONE;
  assign low_load  = (low_cnt  == CNT_ZERO) ? CNT_ZERO : low_cnt  - CNT_ONE;

  // Decide at a LOW-phase end whether another pulse follows. BURST is read
  // live here, so shrinking it below PULSES ends the burst at this boundary.
  assign burst_more = (burst == CNT_ZERO) ? trigger_in : (pulses < burst);

  // Register file: host writes land regardless of the sequencer state.
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values and simulation ordering cannot create races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_cnt <= CNT_ONE;
      low_cnt  <= CNT_ONE;
      burst    <= CNT_ONE;
    end else if (wr_en) begin
      case (address)
        ADDR_HIGH: high_cnt <= writedata[CNT_W-1:0];
        ADDR_LOW:  low_cnt  <= writedata[CNT_W-1:0];
        ADDR_BRST: burst    <= writedata[CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  // Trigger history for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_d <= 1'b0;
    end else begin
      trig_d <= trigger_in;
    end
  end

  // Sequencer state, phase counter and completed-pulse counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase_cnt <= CNT_ZERO;
      pulses    <= CNT_ZERO;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_cnt_nxt;
      pulses    <= pulses_nxt;
    end
  end

  // Next-state logic: abort overrides everything, including a same-cycle edge.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    pulses_nxt    = pulses;

    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_edge) begin
            state_nxt     = ST_HIGH;
            phase_cnt_nxt = high_load;
            pulses_nxt    = CNT_ZERO;
          end
        end
        ST_HIGH: begin
          if (phase_cnt != CNT_ZERO) begin
            phase_cnt_nxt = phase_cnt - CNT_ONE;
          end else begin
            state_nxt     = ST_LOW;
            phase_cnt_nxt = low_load;
            if (pulses != CNT_MAX) begin
              pulses_nxt = pulses + CNT_ONE;
            end
          end
        end
        ST_LOW: begin
          if (phase_cnt != CNT_ZERO) begin
            phase_cnt_nxt = phase_cnt - CNT_ONE;
          end else if (burst_more) begin
            state_nxt     = ST_HIGH;
            phase_cnt_nxt = high_load;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from the registered state: glitch-free on the pin.
  assign sma_out = (state == ST_HIGH);
  assign busy    = (state != ST_IDLE);

  // Combinational read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_HIGH: readdata = 32'(high_cnt);
      ADDR_LOW:  readdata = 32'(low_cnt);
      ADDR_BRST: readdata = 32'(burst);
      default: begin
        readdata[31:16] = 16'(pulses);
        readdata[0]     = busy;
      end
    endcase
  end

endmodule
